// File: rtl/key_click_decoder.sv
// Classifies bursts of debounced key presses into single/double(/triple) click events.
// Triple detection and the WAIT2 state are built only when KEY_CLICK_TRIPLE_EN is defined.
module key_click_decoder #(
  parameter logic [19:0] WINDOW = 20'd500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_pulse,
  output logic       single,
  output logic       double,
  output logic       triple,
  output logic       busy,
  output logic [1:0] click_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT1 = 2'd1
`ifdef KEY_CLICK_TRIPLE_EN
    ,
    WAIT2 = 2'd2
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic        single_q, single_d;
  logic        double_q, double_d;
  logic        timeout;
`ifdef KEY_CLICK_TRIPLE_EN
  logic        triple_q, triple_d;
`endif

  // A pulse coinciding with the last window cycle is a click, not a timeout.
  assign timeout = (cnt_q == WINDOW - 20'd1) && !key_pulse;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
`ifdef KEY_CLICK_TRIPLE_EN
    triple_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = 20'd0;
        if (key_pulse) state_d = WAIT1;
      end
      WAIT1: begin
        if (key_pulse) begin
          cnt_d = 20'd0;
`ifdef KEY_CLICK_TRIPLE_EN
          state_d = WAIT2;
`else
          state_d  = IDLE;
          double_d = 1'b1;
`endif
        end else if (timeout) begin
          state_d  = IDLE;
          cnt_d    = 20'd0;
          single_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
`ifdef KEY_CLICK_TRIPLE_EN
      WAIT2: begin
        if (key_pulse) begin
          state_d  = IDLE;
          cnt_d    = 20'd0;
          triple_d = 1'b1;
        end else if (timeout) begin
          state_d  = IDLE;
          cnt_d    = 20'd0;
          double_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = 20'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 20'd0;
      single_q <= 1'b0;
      double_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
    end
  end

`ifdef KEY_CLICK_TRIPLE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) triple_q <= 1'b0;
    else      triple_q <= triple_d;
  end
  assign triple = triple_q;
`else
  assign triple = 1'b0;
`endif

  assign single = single_q;
  assign double = double_q;
  assign busy   = (state_q != IDLE);

  always_comb begin
    click_cnt = 2'd0;
    case (state_q)
      WAIT1:   click_cnt = 2'd1;
`ifdef KEY_CLICK_TRIPLE_EN
      WAIT2:   click_cnt = 2'd2;
`endif
      default: click_cnt = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_key_click_decoder.sv
// Random and directed click bursts against a deadline-based burst model, WINDOW=8.
module tb_key_click_decoder;
  localparam int W = 8;
`ifdef KEY_CLICK_TRIPLE_EN
  localparam int MAXC = 3;
`else
  localparam int MAXC = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_pulse = 1'b0;
  logic       s_o, d_o, t_o, busy_o;
  logic [1:0] cc_o;

  int vecs = 0;
  int errs = 0;

  // Burst model: open flag, click count, edge of last click, events after this edge.
  bit m_open;
  int m_n, m_last, t;
  bit e1, e2, e3;

  key_click_decoder #(.WINDOW(20'd8)) dut (
    .clk(clk), .rst(rst), .key_pulse(key_pulse),
    .single(s_o), .double(d_o), .triple(t_o),
    .busy(busy_o), .click_cnt(cc_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", t);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d at edge %0d", tag, got, exp, t);
    end
  endtask

  task automatic compare();
    chk("single", {31'd0, s_o}, {31'd0, e1});
    chk("double", {31'd0, d_o}, {31'd0, e2});
    chk("triple", {31'd0, t_o}, {31'd0, e3});
    chk("busy", {31'd0, busy_o}, {31'd0, m_open});
    chk("click_cnt", {30'd0, cc_o}, m_open ? m_n : 0);
  endtask

  task automatic emit(input int n);
    if (n == 1) e1 = 1'b1;
    else if (n == 2) e2 = 1'b1;
    else e3 = 1'b1;
    m_open = 1'b0;
    m_n = 0;
  endtask

  task automatic model_edge(input bit p);
    t++;
    e1 = 1'b0; e2 = 1'b0; e3 = 1'b0;
    if (!m_open) begin
      if (p) begin m_open = 1'b1; m_n = 1; m_last = t; end
    end else if (p) begin
      m_n++;
      if (m_n == MAXC) emit(m_n);
      else m_last = t;
    end else if (t == m_last + W) begin
      emit(m_n);
    end
  endtask

  task automatic step(input bit p);
    @(negedge clk);
    key_pulse = p;
    @(posedge clk);
    model_edge(p);
    #1 compare();
  endtask

  task automatic seq(input int a, input int b, input int c, input int len);
    for (int i = 0; i < len; i++) step(i == a || i == b || i == c);
  endtask

  // Called right after a step: reset asserts between edges and is checked with no clock.
  task automatic mid_reset(input int hold);
    #2;
    key_pulse = 1'b0;
    rst = 1'b0;
    #1;
    m_open = 1'b0; m_n = 0; e1 = 1'b0; e2 = 1'b0; e3 = 1'b0;
    compare();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      t++;
      #1 compare();
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    m_open = 1'b0; m_n = 0; m_last = 0; t = 0;
    e1 = 1'b0; e2 = 1'b0; e3 = 1'b0;
    #12;
    compare();
    @(negedge clk);
    rst = 1'b1;

    seq(10, -1, -1, 30);      // single
    seq(10, 15, -1, 35);      // double
    seq(10, 18, -1, 35);      // boundary: pulse wins at cnt==WINDOW-1
    seq(10, 19, -1, 40);      // boundary: two singles
    seq(10, 14, 18, 40);      // triple / double+single
    seq(10, -1, -1, 14);      // reset mid-burst
    mid_reset(2);
    seq(5, -1, -1, 25);

    for (int blk = 0; blk < 15; blk++) begin
      int thr;
      thr = $urandom_range(1, 12);
      for (int i = 0; i < 200; i++) step($urandom_range(0, thr - 1) == 0);
      if ($urandom_range(0, 2) == 0) mid_reset($urandom_range(0, 3));
    end
    seq(-1, -1, -1, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
